// File: rtl/saper_pkg.sv
// Shared types and constants for the Saper game controller.
// Holds the state encoding, difficulty codes, default timing values and the per-level time limits.
package saper_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    PLAY   = 3'd2,
    SETTLE = 3'd3,
    WON    = 3'd4,
    LOST   = 3'd5
  } game_state_t;

  localparam logic [1:0] LVL_NONE   = 2'd0;
  localparam logic [1:0] LVL_EASY   = 2'd1;
  localparam logic [1:0] LVL_MEDIUM = 2'd2;
  localparam logic [1:0] LVL_HARD   = 2'd3;

  localparam int DEF_CLEAR_CYCLES  = 16;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_TIME_MAX      = 999;
  localparam int TIME_W            = 10;

  localparam logic [TIME_W-1:0] TIME_LIMIT [4] = '{10'd999, 10'd300, 10'd600, 10'd999};

  function automatic logic [TIME_W-1:0] time_limit(input logic [1:0] lvl);
    return TIME_LIMIT[lvl];
  endfunction

endpackage

// File: rtl/sec_counter.sv
// Elapsed-seconds counter: counts tick_1s pulses while enabled and saturates at TIME_MAX.
// A clear takes priority over counting.
module sec_counter #(
  parameter int TIME_MAX = 999,
  parameter int W        = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clear,
  input  logic         tick_1s,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && tick_1s && (count != W'(TIME_MAX))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/game_ctl.sv
// Saper round sequencer: difficulty latch, board clear, play/settle/win/lose FSM and the seconds counter.
// Defining GAME_TIMEOUT_EN adds a per-level time limit that ends the round as LOST.
module game_ctl
  import saper_pkg::*;
#(
  parameter int CLEAR_CYCLES  = DEF_CLEAR_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int TIME_MAX      = DEF_TIME_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        level,
  input  logic              start,
  input  logic              reveal_valid,
  input  logic              reveal_mine,
  input  logic              flag_update,
  input  logic              game_won,
  input  logic              tick_1s,
  output logic [1:0]        level_q,
  output logic              board_clear,
  output logic              game_active,
  output logic              won,
  output logic              lost,
  output logic [TIME_W-1:0] elapsed_s
);

  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  game_state_t   state;
  game_state_t   next_state;
  logic [CW-1:0] clr_cnt;
  logic [SW-1:0] settle_cnt;

  logic restart;
  logic mine_hit;
  logic in_play;
  logic timeout;

  logic board_clear_d;
  logic game_active_d;
  logic won_d;
  logic lost_d;

  assign restart  = start && (level != LVL_NONE);
  assign mine_hit = reveal_valid && reveal_mine;
  assign in_play  = (state == PLAY) || (state == SETTLE);

`ifdef GAME_TIMEOUT_EN
  // Fires on the tick that brings elapsed_s up to the level's limit, together with that increment.
  assign timeout = in_play && tick_1s && ((elapsed_s + TIME_W'(1)) == time_limit(level_q));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      board_clear <= 1'b0;
      game_active <= 1'b0;
      won         <= 1'b0;
      lost        <= 1'b0;
    end else begin
      state       <= next_state;
      board_clear <= board_clear_d;
      game_active <= game_active_d;
      won         <= won_d;
      lost        <= lost_d;
    end
  end

  always_comb begin
    next_state = state;
    if (start) begin
      next_state = restart ? CLEAR : IDLE;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == '0) next_state = PLAY;
        end
        PLAY: begin
          if (mine_hit || timeout) next_state = LOST;
          else if (flag_update)    next_state = SETTLE;
        end
        SETTLE: begin
          // game_won is only trusted on the last settle cycle; a fresh flag change restarts the wait.
          if (mine_hit || timeout)        next_state = LOST;
          else if (flag_update)           next_state = SETTLE;
          else if (settle_cnt == SW'(1))  next_state = game_won ? WON : PLAY;
        end
        default: next_state = state;
      endcase
    end
  end

  always_comb begin
    board_clear_d = (next_state == CLEAR);
    game_active_d = (next_state == PLAY) || (next_state == SETTLE);
    won_d         = (next_state == WON);
    lost_d        = (next_state == LOST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q    <= LVL_NONE;
      clr_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      if (restart) begin
        level_q <= level;
        clr_cnt <= CW'(CLEAR_CYCLES - 1);
      end else if ((state == CLEAR) && (clr_cnt != '0)) begin
        clr_cnt <= clr_cnt - CW'(1);
      end

      if (!start && flag_update && (next_state == SETTLE)) begin
        settle_cnt <= SW'(SETTLE_CYCLES);
      end else if ((state == SETTLE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - SW'(1);
      end
    end
  end

  sec_counter #(
    .TIME_MAX (TIME_MAX),
    .W        (TIME_W)
  ) u_sec_counter (
    .clk     (clk),
    .rst     (rst),
    .enable  (in_play),
    .clear   (restart),
    .tick_1s (tick_1s),
    .count   (elapsed_s)
  );

endmodule
